s2c_call_arb: RTL and testbench
===============================

# s2c_call_arb

Round-robin scheduler that shares the single simulator-to-C function-call channel (id/fn request, ret plus 16-word data response) between several RTL requesters. It accepts one call at a time, issues it on the channel, collects the response beats into an internal packet buffer, and returns the full packet (ret + data) to the requester that owns it. A per-call watchdog converts a hung C side into an error return so the bench keeps running.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- DATA_SIZE, 16: response data words per call.
- TIMEOUT, 1024: max cycles without channel progress before abort (≥2).
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset; one clock; sampled on rising edge of clk.
- req_valid  in  NUM_REQ  per-requester call request; held until its req_ready.
- req_id  in  NUM_REQ*32  per-requester id, slice i = [32*i+:32].
- req_fn  in  NUM_REQ*32  per-requester function code.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- rsp_valid  out  NUM_REQ  one-hot: response for requester i is available.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_ret  out  32  return code of delivered call.
- rsp_data  out  DATA_SIZE*32  response words, word k = [32*k+:32].
- ch_req_valid  out  1  call issued to channel.
- ch_req_id  out  32  issued id.
- ch_req_fn  out  32  issued fn.
- ch_req_ready  in  1  channel accepts call.
- ch_rsp_valid  in  1  response beat valid (always accepted).
- ch_rsp_ret  in  32  return code, meaningful on beat 0 only.
- ch_rsp_data  in  32  data word for current beat.
- busy  out  1  state ≠ IDLE.
- calls_done  out  32  completed deliveries (wraps).
- timeouts  out  16  aborted calls (saturates at 0xFFFF).

## Operation
- States: IDLE, ISSUE, COLLECT, DELIVER.
- IDLE: if any req_valid, grant = first set bit searching from (last_grant+1) mod NUM_REQ upward, wrapping; pulse req_ready[grant] one cycle; latch id/fn; last_grant ← grant; → ISSUE. After reset last_grant = NUM_REQ-1 (requester 0 highest priority first).
- ISSUE: ch_req_valid=1 with latched id/fn, held stable until ch_req_ready; on handshake clear beat counter, → COLLECT.
- COLLECT: each ch_rsp_valid writes ch_rsp_data to buf[beat], beat++; beat 0 also latches ch_rsp_ret. After beat DATA_SIZE-1 → DELIVER.
- DELIVER: rsp_valid[grant]=1, rsp_ret/rsp_data from buffer, stable until rsp_ready[grant]; then calls_done++, → IDLE. rsp_ready on other bits ignored.
- Watchdog: counter cleared on entry to ISSUE and on every ch_rsp_valid in COLLECT; increments otherwise in ISSUE/COLLECT. Reaching TIMEOUT: drop ch_req_valid, rsp_ret ← 0xFFFF_FFFF, unreceived words ← 0, timeouts++ (sat), → DELIVER.
- ch_rsp_valid outside COLLECT is ignored (no buffer write).
- req_valid dropped before accept: simply not granted; behaviour of held fields is requester's responsibility.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_ret=0, rsp_data=0, ch_req_valid=0, ch_req_id=0, ch_req_fn=0, busy=0, calls_done=0, timeouts=0, state IDLE, buffer 0.
- Reset mid-call aborts it: no delivery, counters cleared; a late channel beat is ignored.
- Min latency req_valid→rsp_valid: 1 (accept) + 1 (ISSUE, immediate ready) + DATA_SIZE beats + 1 = DATA_SIZE+3 cycles with back-to-back beats.
- Back-to-back: the cycle after rsp handshake is IDLE; next grant can pulse that cycle. No overlap of calls.
- ch_rsp_valid in the same cycle as ch_req_ready handshake is not captured (channel must wait ≥1 cycle).
- Watchdog fires in the cycle count reaches TIMEOUT; DELIVER visible next cycle.

## Test plan
- Single call: req 0 id=5 fn=1, channel ready immediately, beats data=k+0x100, ret=7 on beat 0 -> rsp_valid=0001 at cycle 19, rsp_ret=7, word 15=0x10F, calls_done=1.
- Round robin: all four req_valid held continuously -> grant order 0,1,2,3,0; never same requester twice while others wait.
- Backpressure: ch_req_ready low 10 cycles, rsp_ready low 5 cycles -> ch_req_id/fn and rsp outputs stable throughout; no extra req_ready pulses.
- Timeout: TIMEOUT=16, channel accepts and sends 3 beats then stalls -> rsp_ret=0xFFFF_FFFF, words 0..2 valid, 3..15 zero, timeouts=1; stray later beat ignored, next call correct.
- Reset mid-COLLECT after 8 beats -> all outputs at reset values next cycle, busy=0, subsequent call from requester 0 completes normally.
- Stray ch_rsp_valid in IDLE, 5 pulses -> buffer and counters unchanged.

Source files
------------

// File: rtl/s2c_call_arb.sv
// Round-robin arbiter for the shared simulator-to-C call channel: accepts one
// call, issues it, buffers the response beats and returns the packet to its owner.
module s2c_call_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*32-1:0]     req_id,
  input  logic [NUM_REQ*32-1:0]     req_fn,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [31:0]               rsp_ret,
  output logic [DATA_SIZE*32-1:0]   rsp_data,
  output logic                      ch_req_valid,
  output logic [31:0]               ch_req_id,
  output logic [31:0]               ch_req_fn,
  input  logic                      ch_req_ready,
  input  logic                      ch_rsp_valid,
  input  logic [31:0]               ch_rsp_ret,
  input  logic [31:0]               ch_rsp_data,
  output logic                      busy,
  output logic [31:0]               calls_done,
  output logic [15:0]               timeouts
);
  localparam int unsigned NR = NUM_REQ;
  localparam int unsigned DS = DATA_SIZE;
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, DELIVER} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [31:0]   id_q, id_d, fn_q, fn_d, ret_q, ret_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [31:0]   data_buf_q [DATA_SIZE];
  logic [31:0]   data_buf_d [DATA_SIZE];
  logic [31:0]   calls_done_q, calls_done_d;
  logic [15:0]   timeouts_q, timeouts_d;
  logic [GW-1:0] pick;
  logic          pick_ok;
  logic          stall;
  int unsigned   idx;

  // First requesting index strictly after the previous grant, wrapping.
  always_comb begin
    pick    = last_grant_q;
    pick_ok = 1'b0;
    idx     = 0;
    for (int unsigned off = 1; off <= NR; off++) begin
      idx = (32'(last_grant_q) + off) % NR;
      if (!pick_ok && req_valid[GW'(idx)]) begin
        pick    = GW'(idx);
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    fn_d         = fn_q;
    ret_d        = ret_q;
    beat_d       = beat_q;
    wd_d         = wd_q;
    data_buf_d   = data_buf_q;
    calls_done_d = calls_done_q;
    timeouts_d   = timeouts_q;
    req_ready    = '0;
    rsp_valid    = '0;
    ch_req_valid = 1'b0;
    stall        = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_ok) begin
          req_ready[pick] = 1'b1;
          last_grant_d    = pick;
          id_d            = req_id[32*pick +: 32];
          fn_d            = req_fn[32*pick +: 32];
          beat_d          = '0;
          wd_d            = '0;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        ch_req_valid = 1'b1;
        if (ch_req_ready) begin
          beat_d  = '0;
          wd_d    = '0;
          state_d = COLLECT;
        end else begin
          stall = 1'b1;
        end
      end
      COLLECT: begin
        if (ch_rsp_valid) begin
          data_buf_d[beat_q] = ch_rsp_data;
          if (beat_q == '0) ret_d = ch_rsp_ret;
          beat_d = beat_q + BW'(1);
          wd_d   = '0;
          if (beat_q == BW'(DATA_SIZE - 1)) state_d = DELIVER;
        end else begin
          stall = 1'b1;
        end
      end
      DELIVER: begin
        rsp_valid[last_grant_q] = 1'b1;
        if (rsp_ready[last_grant_q]) begin
          calls_done_d = calls_done_q + 32'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog abort: words not yet received are zeroed so the packet is deterministic.
    if (stall) begin
      if (wd_q == WW'(TIMEOUT - 1)) begin
        ret_d = '1;
        for (int unsigned k = 0; k < DS; k++) begin
          if (k >= 32'(beat_q)) data_buf_d[BW'(k)] = '0;
        end
        if (timeouts_q != '1) timeouts_d = timeouts_q + 16'd1;
        state_d = DELIVER;
      end else begin
        wd_d = wd_q + WW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      id_q         <= '0;
      fn_q         <= '0;
      ret_q        <= '0;
      beat_q       <= '0;
      wd_q         <= '0;
      data_buf_q   <= '{default: '0};
      calls_done_q <= '0;
      timeouts_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      fn_q         <= fn_d;
      ret_q        <= ret_d;
      beat_q       <= beat_d;
      wd_q         <= wd_d;
      data_buf_q   <= data_buf_d;
      calls_done_q <= calls_done_d;
      timeouts_q   <= timeouts_d;
    end
  end

  always_comb begin
    rsp_data = '0;
    for (int unsigned k = 0; k < DS; k++) begin
      rsp_data[32*k +: 32] = data_buf_q[BW'(k)];
    end
  end

  assign ch_req_id  = id_q;
  assign ch_req_fn  = fn_q;
  assign rsp_ret    = ret_q;
  assign busy       = (state_q != IDLE);
  assign calls_done = calls_done_q;
  assign timeouts   = timeouts_q;

endmodule

// File: tb/tb_s2c_call_arb.sv
// Directed bench for s2c_call_arb: a call-level model checked every cycle,
// plus literal expectations for the single-call, round-robin, backpressure,
// watchdog, mid-call reset and stray-beat cases.
module tb_s2c_call_arb;
  localparam int N  = 4;
  localparam int DS = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [N-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*32-1:0]    req_id, req_fn;
  logic [31:0]        rsp_ret;
  logic [DS*32-1:0]   rsp_data;
  logic               ch_req_valid, ch_req_ready, ch_rsp_valid;
  logic [31:0]        ch_req_id, ch_req_fn, ch_rsp_ret, ch_rsp_data;
  logic               busy;
  logic [31:0]        calls_done;
  logic [15:0]        timeouts;

  s2c_call_arb #(.NUM_REQ(N), .DATA_SIZE(DS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_id(req_id), .req_fn(req_fn), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ret(rsp_ret), .rsp_data(rsp_data),
    .ch_req_valid(ch_req_valid), .ch_req_id(ch_req_id), .ch_req_fn(ch_req_fn),
    .ch_req_ready(ch_req_ready), .ch_rsp_valid(ch_rsp_valid), .ch_rsp_ret(ch_rsp_ret),
    .ch_rsp_data(ch_rsp_data), .busy(busy), .calls_done(calls_done), .timeouts(timeouts)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: where the single outstanding call is (0 idle, 1 issuing, 2 collecting, 3 delivering).
  int          m_phase;
  int unsigned m_last, m_owner, m_beats, m_idle, m_done, m_to;
  logic [31:0] m_id, m_fn, m_ret;
  logic [31:0] m_buf [DS];

  // Agent / observation state.
  int          cycle = 0;
  logic        chk_en = 1'b0;
  logic [N-1:0] acc;
  logic        hs;
  logic        saw_rv;
  int          rsp_first_cycle;
  logic        prev_rv = 1'b0;
  logic [N-1:0] obs_rv;
  logic [31:0] obs_ret;
  logic [DS*32-1:0] obs_data;
  int          deliveries = 0;
  int          ready_pulses = 0;
  int unsigned grant_log [$];
  logic        hold_all = 1'b0;
  int          rr_target = 0;
  logic        sending = 1'b0;
  int          sent = 0;
  int          beat_limit = DS;
  int          stray = 0;
  logic [31:0] data_base, ret_val;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [DS*32-1:0] d, input int k);
    return d[32*k +: 32];
  endfunction

  // Closest requester after 'last' going round the ring.
  function automatic int unsigned rr_pick(input int unsigned last, input logic [N-1:0] v);
    int unsigned best, best_d;
    best = 0;
    best_d = N;
    for (int c = 0; c < N; c++) begin
      if (v[c]) begin
        int unsigned d;
        d = (c + N - last - 1) % N;
        if (d < best_d) begin
          best = c;
          best_d = d;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [DS*32-1:0] pack_buf();
    logic [DS*32-1:0] v;
    for (int k = 0; k < DS; k++) v[32*k +: 32] = m_buf[k];
    return v;
  endfunction

  task automatic model_abort_step();
    m_idle++;
    if (m_idle == TO) begin
      m_ret = 32'hFFFF_FFFF;
      for (int k = 0; k < DS; k++) if (k >= int'(m_beats)) m_buf[k] = '0;
      if (m_to < 32'hFFFF) m_to++;
      m_phase = 3;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_phase = 0; m_last = N - 1; m_owner = 0; m_beats = 0; m_idle = 0;
      m_done = 0; m_to = 0; m_id = '0; m_fn = '0; m_ret = '0;
      for (int k = 0; k < DS; k++) m_buf[k] = '0;
      return;
    end
    case (m_phase)
      0: if (req_valid != '0) begin
        m_owner = rr_pick(m_last, req_valid);
        m_last  = m_owner;
        m_id    = req_id[32*m_owner +: 32];
        m_fn    = req_fn[32*m_owner +: 32];
        m_beats = 0;
        m_idle  = 0;
        m_phase = 1;
      end
      1: if (ch_req_ready) begin
        m_phase = 2;
        m_idle  = 0;
      end else model_abort_step();
      2: if (ch_rsp_valid) begin
        if (m_beats == 0) m_ret = ch_rsp_ret;
        m_buf[m_beats] = ch_rsp_data;
        m_beats++;
        m_idle = 0;
        if (m_beats == DS) m_phase = 3;
      end else model_abort_step();
      3: if (rsp_ready[m_owner]) begin
        m_done++;
        m_phase = 0;
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    logic [N-1:0] e_rdy, e_val;
    e_rdy = '0;
    if (m_phase == 0 && req_valid != '0) e_rdy[rr_pick(m_last, req_valid)] = 1'b1;
    e_val = '0;
    if (m_phase == 3) e_val[m_owner] = 1'b1;
    check("req_ready", req_ready, e_rdy);
    check("rsp_valid", rsp_valid, e_val);
    check("busy", busy, m_phase != 0);
    check("ch_req_valid", ch_req_valid, m_phase == 1);
    if (m_phase == 1) begin
      check("ch_req_id", ch_req_id, m_id);
      check("ch_req_fn", ch_req_fn, m_fn);
    end
    if (m_phase == 3) begin
      check("rsp_ret", rsp_ret, m_ret);
      check("rsp_data", rsp_data, pack_buf());
    end
    check("calls_done", calls_done, m_done);
    check("timeouts", timeouts, m_to[15:0]);
  endtask

  task automatic observe();
    acc = req_ready & req_valid;
    for (int i = 0; i < N; i++) if (acc[i]) grant_log.push_back(i);
    ready_pulses += $countones(req_ready);
    hs = ch_req_valid & ch_req_ready;
    if (rsp_valid != '0) begin
      if (!prev_rv) rsp_first_cycle = cycle;
      saw_rv   = 1'b1;
      obs_rv   = rsp_valid;
      obs_ret  = rsp_ret;
      obs_data = rsp_data;
      if ((rsp_valid & rsp_ready) != '0) deliveries++;
    end
    prev_rv = (rsp_valid != '0);
  endtask

  task automatic drive_next();
    if (hold_all) begin
      if (grant_log.size() >= rr_target) begin
        hold_all  = 1'b0;
        req_valid = '0;
      end
    end else begin
      req_valid = req_valid & ~acc;
    end
    if (hs) begin
      sending = 1'b1;
      sent    = 0;
    end
    if (sending && sent < beat_limit) begin
      ch_rsp_valid = 1'b1;
      ch_rsp_data  = data_base + sent;
      ch_rsp_ret   = (sent == 0) ? ret_val : (32'hBAD0_0000 | sent);
      sent++;
    end else begin
      sending = 1'b0;
      if (stray > 0) begin
        ch_rsp_valid = 1'b1;
        ch_rsp_data  = 32'hDEAD_BEEF;
        ch_rsp_ret   = 32'h5555_5555;
        stray--;
      end else begin
        ch_rsp_valid = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    cycle++;
    if (chk_en) compare_all();
    observe();
    @(posedge clk);
    model_step();
    #1;
    drive_next();
  endtask

  task automatic wait_deliver(input string name, input int maxc);
    int n;
    n = 0;
    saw_rv = 1'b0;
    while (!saw_rv && n < maxc) begin
      cyc();
      n++;
    end
    check({name, "_rsp_seen"}, saw_rv, 1'b1);
  endtask

  task automatic wait_accept(input string name, input int maxc);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (acc == '0 && n < maxc);
    check({name, "_accept_seen"}, acc != '0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int start_cycle, base_n, pulses0, n;
    int unsigned exp_rr [5];
    exp_rr = '{0, 1, 2, 3, 0};
    rst_n = 1'b0; req_valid = '0; req_id = '0; req_fn = '0; rsp_ready = '1;
    ch_req_ready = 1'b1; ch_rsp_valid = 1'b0; ch_rsp_ret = '0; ch_rsp_data = '0;
    data_base = 32'h100; ret_val = 32'd7;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst_n = 1'b1;

    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 4'b0000);
    check("rst_ch_req_valid", ch_req_valid, 1'b0);
    check("rst_ch_req_id", ch_req_id, 32'h0);
    check("rst_ch_req_fn", ch_req_fn, 32'h0);
    check("rst_calls_done", calls_done, 32'h0);

    // Stray beats while idle.
    stray = 5;
    repeat (7) cyc();
    check("stray_rsp_data", rsp_data, '0);
    check("stray_rsp_ret", rsp_ret, 32'h0);
    check("stray_busy", busy, 1'b0);
    check("stray_timeouts", timeouts, 16'h0);

    // Single call from requester 0.
    req_id[31:0] = 32'd5; req_fn[31:0] = 32'd1; req_valid[0] = 1'b1;
    start_cycle = cycle + 1;
    wait_deliver("single", 40);
    check("single_latency", rsp_first_cycle - start_cycle + 1, 19);
    check("single_owner", obs_rv, 4'b0001);
    check("single_ret", obs_ret, 32'd7);
    check("single_word0", word(obs_data, 0), 32'h100);
    check("single_word15", word(obs_data, 15), 32'h10F);
    check("single_calls_done", calls_done, 32'd1);

    // Round robin with everyone requesting continuously.
    do_reset();
    check("rr_rst_calls_done", calls_done, 32'd0);
    for (int i = 0; i < N; i++) begin
      req_id[32*i +: 32] = 32'h10 + i;
      req_fn[32*i +: 32] = 32'h20 + i;
    end
    data_base = 32'h200; ret_val = 32'h20;
    grant_log.delete();
    rr_target = 5; hold_all = 1'b1; req_valid = '1;
    base_n = deliveries; n = 0;
    while (deliveries < base_n + 5 && n < 200) begin
      cyc();
      n++;
    end
    check("rr_deliveries", deliveries - base_n, 5);
    for (int i = 0; i < 5; i++)
      check("rr_grant", (i < grant_log.size()) ? grant_log[i] : 99, exp_rr[i]);

    // Backpressure on both the channel request and the response.
    ch_req_ready = 1'b0; rsp_ready = 4'b1101;
    data_base = 32'h300; ret_val = 32'h30;
    req_id[63:32] = 32'hAA; req_fn[63:32] = 32'hBB; req_valid[1] = 1'b1;
    pulses0 = ready_pulses;
    wait_accept("bp", 10);
    for (int i = 0; i < 10; i++) begin
      check("bp_ch_valid", ch_req_valid, 1'b1);
      check("bp_ch_id", ch_req_id, 32'hAA);
      check("bp_ch_fn", ch_req_fn, 32'hBB);
      cyc();
    end
    ch_req_ready = 1'b1;
    wait_deliver("bp", 40);
    for (int i = 0; i < 4; i++) begin
      check("bp_rsp_valid", rsp_valid, 4'b0010);
      check("bp_rsp_ret", rsp_ret, 32'h30);
      cyc();
    end
    rsp_ready = '1;
    cyc();
    check("bp_busy_after", busy, 1'b0);
    check("bp_calls_done", calls_done, 32'd6);
    check("bp_ready_pulses", ready_pulses - pulses0, 1);

    // Channel stalls after three beats.
    beat_limit = 3; data_base = 32'h400; ret_val = 32'h40;
    req_id[95:64] = 32'h44; req_fn[95:64] = 32'h45; req_valid[2] = 1'b1;
    wait_deliver("to", 60);
    check("to_owner", obs_rv, 4'b0100);
    check("to_ret", obs_ret, 32'hFFFF_FFFF);
    check("to_word0", word(obs_data, 0), 32'h400);
    check("to_word2", word(obs_data, 2), 32'h402);
    check("to_word3", word(obs_data, 3), 32'h0);
    check("to_word15", word(obs_data, 15), 32'h0);
    check("to_count", timeouts, 16'd1);
    stray = 1;
    repeat (3) cyc();
    beat_limit = DS; data_base = 32'h600; ret_val = 32'h60;
    req_id[127:96] = 32'h66; req_fn[127:96] = 32'h67; req_valid[3] = 1'b1;
    wait_deliver("after_to", 40);
    check("after_to_ret", obs_ret, 32'h60);
    check("after_to_word0", word(obs_data, 0), 32'h600);
    check("after_to_word15", word(obs_data, 15), 32'h60F);

    // Reset in the middle of collecting.
    data_base = 32'h500; ret_val = 32'h50;
    req_valid[0] = 1'b1;
    n = 0;
    while (sent < 8 && n < 30) begin
      cyc();
      n++;
    end
    check("mid_beats_sent", sent >= 8, 1'b1);
    cyc();
    do_reset();
    check("mid_busy", busy, 1'b0);
    check("mid_rsp_valid", rsp_valid, 4'b0000);
    check("mid_ch_valid", ch_req_valid, 1'b0);
    check("mid_calls_done", calls_done, 32'd0);
    check("mid_timeouts", timeouts, 16'd0);
    check("mid_rsp_ret", rsp_ret, 32'h0);
    check("mid_rsp_data", rsp_data, '0);
    repeat (10) cyc();
    data_base = 32'h700; ret_val = 32'h70;
    req_id[31:0] = 32'h77; req_valid[0] = 1'b1;
    wait_deliver("post_rst", 40);
    check("post_rst_owner", obs_rv, 4'b0001);
    check("post_rst_ret", obs_ret, 32'h70);
    check("post_rst_word5", word(obs_data, 5), 32'h705);
    check("post_rst_calls_done", calls_done, 32'd1);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
